// File: rtl/fanin_merge_rr.sv
// Three-lane round-robin merge into a 2-entry output FIFO with a clock enable.
// Defining FANIN_TAG_EN adds tag_out, the source lane of the FIFO head.
module fanin_merge_rr #(
    parameter int DATA_WIDTH = 17,
    parameter int SEL_BIT    = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  E0,
    input  logic                  E1,
    input  logic                  E2,
    input  logic [31:0]           S0,
    input  logic [31:0]           S1,
    input  logic [31:0]           S2,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    output logic                  ready_out0,
    output logic                  ready_out1,
    output logic                  ready_out2,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef FANIN_TAG_EN
    output logic [1:0]            tag_out,
`endif
    input  logic                  ready_in
);

    // Handshake: a word moves on a cycle where valid and ready are both high
    // (and clk_en is high); ready never depends on the same-side valid of the
    // other lanes except through the arbiter's request vector.
    logic [2:0]            part;
    logic [2:0]            req;
    logic [2:0]            grant;
    logic [1:0]            grant_idx;
    logic [2:0]            ready_vec;
    logic                  can_accept;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    logic [1:0]            count;
    logic [1:0]            ptr;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] mem [2];
`ifdef FANIN_TAG_EN
    logic [1:0]            tag_mem [2];
`endif

    assign part = {E2 & S2[SEL_BIT], E1 & S1[SEL_BIT], E0 & S0[SEL_BIT]};
    assign req  = part & {valid_in2, valid_in1, valid_in0};

    // Search order starts at ptr and wraps modulo 3.
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        case (ptr)
            2'd1: begin
                if      (req[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                else if (req[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                else if (req[0]) begin grant = 3'b001; grant_idx = 2'd0; end
            end
            2'd2: begin
                if      (req[2]) begin grant = 3'b100; grant_idx = 2'd2; end
                else if (req[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                else if (req[1]) begin grant = 3'b010; grant_idx = 2'd1; end
            end
            default: begin
                if      (req[0]) begin grant = 3'b001; grant_idx = 2'd0; end
                else if (req[1]) begin grant = 3'b010; grant_idx = 2'd1; end
                else if (req[2]) begin grant = 3'b100; grant_idx = 2'd2; end
            end
        endcase
    end

    assign can_accept = clk_en & (count < 2'd2);
    // rst_n gates ready so producers see 0 during reset without waiting for a clock.
    assign ready_vec  = {3{rst_n & can_accept}} & grant;
    assign ready_out0 = ready_vec[0];
    assign ready_out1 = ready_vec[1];
    assign ready_out2 = ready_vec[2];

    assign push = |(ready_vec & {valid_in2, valid_in1, valid_in0});
    assign pop  = valid_out & ready_in & clk_en;

    always_comb begin
        case (grant_idx)
            2'd1:    push_data = data_in1;
            2'd2:    push_data = data_in2;
            default: push_data = data_in0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            ptr    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
`ifdef FANIN_TAG_EN
                tag_mem[i] <= 2'd0;
`endif
            end
        end else if (clk_en) begin
            if (push) begin
                mem[wr_ptr] <= push_data;
`ifdef FANIN_TAG_EN
                tag_mem[wr_ptr] <= grant_idx;
`endif
                wr_ptr <= ~wr_ptr;
                ptr    <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign valid_out = (count != 2'd0);
    assign data_out  = mem[rd_ptr];
`ifdef FANIN_TAG_EN
    assign tag_out   = tag_mem[rd_ptr];
`endif

endmodule

// File: doc/fanin_merge_rr.md
FANIN_MERGE_RR -- requirements
Module: fanin_merge_rr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17, giving the payload width of every data port.
REQ-002 SHALL have parameter SEL_BIT, default 20, giving the config-word bit that selects an input lane.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clk_en, input, 1, global clock enable.
REQ-006 SHALL have ports E0/E1/E2, input, 1 each, lane enable.
REQ-007 SHALL have ports S0/S1/S2, input, 32 each, lane config word; bit SEL_BIT selects the lane.
REQ-008 SHALL have ports valid_in0/1/2, input, 1 each, producer valid.
REQ-009 SHALL have ports data_in0/1/2, input, DATA_WIDTH each, producer payload.
REQ-010 SHALL have ports ready_out0/1/2, output, 1 each, ready back to each producer.
REQ-011 SHALL have port valid_out, output, 1, merged stream valid.
REQ-012 SHALL have port data_out, output, DATA_WIDTH, merged stream payload.
REQ-013 SHALL have port ready_in, input, 1, consumer ready.

Function
REQ-014 Lane i SHALL participate iff E_i & S_i[SEL_BIT]; request r_i = participating & valid_in_i.
REQ-015 A non-participating lane SHALL drive ready_out_i = 0 and SHALL never be granted.
REQ-016 The block SHALL hold a 2-entry output FIFO (count 0..2); can_accept = clk_en & (count < 2).
REQ-017 Grant SHALL be one-hot round-robin over r_i, searching from pointer ptr (0..2) upward, mod 3.
REQ-018 ready_out_i SHALL be 1 iff can_accept & grant_i; combinational from registered state and request inputs.
REQ-019 Push SHALL occur iff some ready_out_i & valid_in_i; the FIFO stores data_in of the granted lane.
REQ-020 On push from lane g, ptr SHALL become (g+1) mod 3; otherwise ptr SHALL hold.
REQ-021 valid_out SHALL equal (count != 0); data_out SHALL show the FIFO head; pop occurs iff valid_out & ready_in & clk_en.
REQ-022 Latency SHALL be exactly 1 cycle from a push into an empty FIFO to valid_out = 1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order; at count 2, push is blocked even when pop occurs.
REQ-024 With clk_en = 0, no state SHALL change and all ready_out_i SHALL be 0; valid_out/data_out SHALL hold.
REQ-025 Changing E_i or S_i mid-stream SHALL take effect in the same cycle for grant; already-buffered entries SHALL still drain.
REQ-026 The block SHALL never drop, duplicate or reorder an accepted word.

Reset
REQ-027 On rst_n low, asynchronously: count = 0, ptr = 0, FIFO storage = 0, valid_out = 0, data_out = 0.
REQ-028 All ready_out_i SHALL be 0 while rst_n is low; normal operation resumes on the first clk edge after deassertion.

Configuration
REQ-029 With macro FANIN_TAG_EN defined, the block SHALL add output tag_out [1:0] carrying the source lane index of the FIFO head, stored per entry, reset to 0.
REQ-030 Without FANIN_TAG_EN, tag_out and its per-entry storage SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Only lane 1 participating, valid_in1 = 1 with data 0x00A, 0x00B, ready_in = 1 -> data_out 0x00A then 0x00B, each 1 cycle after acceptance; ready_out0/2 stay 0.
REQ-032 All three lanes participating and valid continuously, ready_in = 1 -> grants cycle lane 0, 1, 2, 0, ... (tag_out 0,1,2,0 when FANIN_TAG_EN).
REQ-033 ready_in = 0, lane 0 valid -> exactly 2 words accepted, then ready_out0 = 0; raise ready_in -> words drain in order, then acceptance resumes.
REQ-034 E2 = 1 but S2[20] = 0, valid_in2 = 1 -> ready_out2 = 0 and valid_out stays 0 forever.
REQ-035 Assert rst_n low with count = 2 mid-stream -> valid_out = 0 and ready_out all 0 immediately, without a clock edge; after release, ptr = 0, so lane 0 wins the first 3-way contention.
REQ-036 clk_en = 0 for 5 cycles with the FIFO holding 1 word and ready_in = 1 -> count, data_out and ptr are unchanged and no ready_out is asserted.
